issue_queue: RTL and testbench

Reservation-station queue on the consuming end of the common data bus. It accepts renamed micro-ops from dispatch and snoops the single CDB broadcast to mark source physical registers ready. It then issues ready micro-ops to one functional unit through a valid/ready handshake. One instance sits in front of each FU (ALU, LSU, BRU); operand data is read from the PRF after issue, so the queue tracks readiness only.

---
 rtl/ooop_types.sv | 40 ++++
 rtl/prio_pick.sv | 16 +
 rtl/issue_queue.sv | 139 +++++++++++++
 tb/tb_issue_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ooop_types.sv
// Shared types for the out-of-order pipeline: issue-queue entry layout and
// physical-register constants.
// Latency: n/a (types only). Backpressure: n/a.
package ooop_types;

  // Widths of the default build; issue_queue parameters default to these.
  localparam int IQ_OP_W  = 32;
  localparam int IQ_TAG_W = 7;

  // Physical register 0 is the "no register" encoding: never busy, never broadcast.
  localparam logic [IQ_TAG_W-1:0] PREG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic [IQ_OP_W-1:0]  payload;
    logic [IQ_TAG_W-1:0] rob_tag;
    logic [IQ_TAG_W-1:0] prd;
    logic                rd_used;
    logic [IQ_TAG_W-1:0] prs1;
    logic                rdy1;
    logic [IQ_TAG_W-1:0] prs2;
    logic                rdy2;
  } iq_entry_t;

  // True when a CDB broadcast produces physical register prs.
  function automatic logic cdb_hit(input logic                cdb_v,
                                   input logic [IQ_TAG_W-1:0] cdb_prd,
                                   input logic [IQ_TAG_W-1:0] prs);
    return cdb_v && (cdb_prd != PREG_ZERO) && (cdb_prd == prs);
  endfunction

  // Source readiness at dispatch time, including same-cycle CDB bypass.
  function automatic logic src_ready(input logic [IQ_TAG_W-1:0] prs,
                                     input logic                busy_rdy,
                                     input logic                cdb_v,
                                     input logic [IQ_TAG_W-1:0] cdb_prd);
    return busy_rdy || (prs == PREG_ZERO) || cdb_hit(cdb_v, cdb_prd, prs);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Fixed-priority picker: one-hot grant of the lowest-index set request bit.
// Latency: combinational. Backpressure: none (pure function of req_i).
// Ports: req_i request vector; gnt_o one-hot grant; any_o some request set.
module prio_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));
  assign any_o = |req_i;

endmodule

// File: rtl/issue_queue.sv
// Reservation-station queue: holds renamed uops, wakes sources from the CDB,
// issues the lowest-index ready uop. Latency: dispatch->issue >= 1 cycle, CDB->eligible 1 cycle.
// Backpressure: disp_ready_o drops when full (registered count); issue holds on !iss_ready_i.
// Ports: clk/rst (sync, active-high), flush_i; disp_* dispatch side; cdb_* wakeup
// broadcast; iss_* valid/ready issue side to the FU; count_o occupancy.
module issue_queue
  import ooop_types::*;
#(
  parameter int DEPTH = 8,
  parameter int OP_W  = IQ_OP_W,   // must match the package entry layout
  parameter int TAG_W = IQ_TAG_W   // must match the package entry layout
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  logic [OP_W-1:0]            disp_payload_i,
  input  logic [TAG_W-1:0]           disp_rob_tag_i,
  input  logic [TAG_W-1:0]           disp_prd_i,
  input  logic                       disp_rd_used_i,
  input  logic [TAG_W-1:0]           disp_prs1_i,
  input  logic [TAG_W-1:0]           disp_prs2_i,
  input  logic                       disp_rs1_rdy_i,
  input  logic                       disp_rs2_rdy_i,
  input  logic                       cdb_valid_i,
  input  logic [TAG_W-1:0]           cdb_prd_i,
  output logic                       iss_valid_o,
  input  logic                       iss_ready_i,
  output logic [OP_W-1:0]            iss_payload_o,
  output logic [TAG_W-1:0]           iss_rob_tag_o,
  output logic [TAG_W-1:0]           iss_prd_o,
  output logic [TAG_W-1:0]           iss_prs1_o,
  output logic [TAG_W-1:0]           iss_prs2_o,
  output logic                       iss_rd_used_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  iq_entry_t        entries_q [DEPTH];
  iq_entry_t        entries_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] valid_vec, ready_vec;
  logic [DEPTH-1:0] free_gnt, iss_gnt;
  logic             free_any, iss_any;
  logic             disp_fire, iss_fire;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      ready_vec[i] = entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2;
    end
  end

  prio_pick #(.N(DEPTH)) u_free_pick (
    .req_i (~valid_vec),
    .gnt_o (free_gnt),
    .any_o (free_any)
  );

  prio_pick #(.N(DEPTH)) u_iss_pick (
    .req_i (ready_vec),
    .gnt_o (iss_gnt),
    .any_o (iss_any)
  );

  // Full is judged from the registered count only, so a slot freed by an
  // issue this cycle is not reusable until the next cycle.
  assign disp_ready_o = (count_q != CNT_W'(DEPTH));
  assign disp_fire    = disp_valid_i && disp_ready_o && free_any;
  assign iss_valid_o  = iss_any;
  assign iss_fire     = iss_any && iss_ready_i;
  assign count_o      = count_q;

  // AND-OR mux over the one-hot grant; all fields read 0 when nothing is ready.
  always_comb begin
    iss_payload_o = '0;
    iss_rob_tag_o = '0;
    iss_prd_o     = '0;
    iss_prs1_o    = '0;
    iss_prs2_o    = '0;
    iss_rd_used_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_gnt[i]) begin
        iss_payload_o = iss_payload_o | entries_q[i].payload;
        iss_rob_tag_o = iss_rob_tag_o | entries_q[i].rob_tag;
        iss_prd_o     = iss_prd_o     | entries_q[i].prd;
        iss_prs1_o    = iss_prs1_o    | entries_q[i].prs1;
        iss_prs2_o    = iss_prs2_o    | entries_q[i].prs2;
        iss_rd_used_o = iss_rd_used_o | entries_q[i].rd_used;
      end
    end
  end

  // Next-state: wakeup on held entries, clear the issued slot, write the free slot.
  // The issued slot is always valid and the free slot never is, so they cannot collide.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if (cdb_hit(cdb_valid_i, cdb_prd_i, entries_q[i].prs1)) entries_d[i].rdy1 = 1'b1;
        if (cdb_hit(cdb_valid_i, cdb_prd_i, entries_q[i].prs2)) entries_d[i].rdy2 = 1'b1;
      end
      if (iss_fire && iss_gnt[i]) begin
        entries_d[i].valid = 1'b0;
      end
      if (disp_fire && free_gnt[i]) begin
        entries_d[i].valid   = 1'b1;
        entries_d[i].payload = disp_payload_i;
        entries_d[i].rob_tag = disp_rob_tag_i;
        entries_d[i].prd     = disp_prd_i;
        entries_d[i].rd_used = disp_rd_used_i;
        entries_d[i].prs1    = disp_prs1_i;
        entries_d[i].prs2    = disp_prs2_i;
        entries_d[i].rdy1    = src_ready(disp_prs1_i, disp_rs1_rdy_i, cdb_valid_i, cdb_prd_i);
        entries_d[i].rdy2    = src_ready(disp_prs2_i, disp_rs2_rdy_i, cdb_valid_i, cdb_prd_i);
      end
    end
    count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
  end

  // Flush and reset take precedence over everything else in that cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with hand-computed expectations.
// Latency: n/a. Backpressure: drives iss_ready_i low/high explicitly.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        disp_valid_i;
  logic        disp_ready_o;
  logic [31:0] disp_payload_i;
  logic [6:0]  disp_rob_tag_i, disp_prd_i, disp_prs1_i, disp_prs2_i;
  logic        disp_rd_used_i, disp_rs1_rdy_i, disp_rs2_rdy_i;
  logic        cdb_valid_i;
  logic [6:0]  cdb_prd_i;
  logic        iss_valid_o, iss_ready_i;
  logic [31:0] iss_payload_o;
  logic [6:0]  iss_rob_tag_o, iss_prd_o, iss_prs1_o, iss_prs2_o;
  logic        iss_rd_used_o;
  logic [3:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  issue_queue #(.DEPTH(8), .OP_W(32), .TAG_W(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .disp_valid_i   (disp_valid_i),
    .disp_ready_o   (disp_ready_o),
    .disp_payload_i (disp_payload_i),
    .disp_rob_tag_i (disp_rob_tag_i),
    .disp_prd_i     (disp_prd_i),
    .disp_rd_used_i (disp_rd_used_i),
    .disp_prs1_i    (disp_prs1_i),
    .disp_prs2_i    (disp_prs2_i),
    .disp_rs1_rdy_i (disp_rs1_rdy_i),
    .disp_rs2_rdy_i (disp_rs2_rdy_i),
    .cdb_valid_i    (cdb_valid_i),
    .cdb_prd_i      (cdb_prd_i),
    .iss_valid_o    (iss_valid_o),
    .iss_ready_i    (iss_ready_i),
    .iss_payload_o  (iss_payload_o),
    .iss_rob_tag_o  (iss_rob_tag_o),
    .iss_prd_o      (iss_prd_o),
    .iss_prs1_o     (iss_prs1_o),
    .iss_prs2_o     (iss_prs2_o),
    .iss_rd_used_o  (iss_rd_used_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [6:0] rob, input logic [6:0] prd,
                          input logic [6:0] p1, input logic r1,
                          input logic [6:0] p2, input logic r2,
                          input logic [31:0] pay);
    disp_valid_i   = 1'b1;
    disp_rob_tag_i = rob;
    disp_prd_i     = prd;
    disp_rd_used_i = 1'b1;
    disp_prs1_i    = p1;
    disp_rs1_rdy_i = r1;
    disp_prs2_i    = p2;
    disp_rs2_rdy_i = r2;
    disp_payload_i = pay;
  endtask

  task automatic idle_inputs();
    disp_valid_i = 1'b0;
    cdb_valid_i  = 1'b0;
    cdb_prd_i    = '0;
    flush_i      = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    set_disp(0, 0, 0, 0, 0, 0, 0);
    disp_valid_i = 1'b0;
    iss_ready_i  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", count_o, 0);
    check("rst_disp_ready", disp_ready_o, 1);
    check("rst_iss_valid", iss_valid_o, 0);
    check("rst_iss_payload", iss_payload_o, 0);
    check("rst_iss_rob_tag", iss_rob_tag_o, 0);

    // Ready-at-dispatch: issue visible one cycle later, then slot freed
    set_disp(3, 10, 5, 1, 6, 1, 32'hA5A5_0001);
    tick();
    disp_valid_i = 1'b0;
    check("t1_iss_valid", iss_valid_o, 1);
    check("t1_rob_tag", iss_rob_tag_o, 3);
    check("t1_prd", iss_prd_o, 10);
    check("t1_payload", iss_payload_o, 32'hA5A5_0001);
    check("t1_prs1", iss_prs1_o, 5);
    check("t1_prs2", iss_prs2_o, 6);
    check("t1_rd_used", iss_rd_used_o, 1);
    check("t1_count1", count_o, 1);
    tick();
    check("t1_count0", count_o, 0);
    check("t1_iss_idle", iss_valid_o, 0);

    // CDB wakeup two cycles after dispatch; eligibility exactly one cycle after CDB
    set_disp(4, 11, 12, 0, 0, 0, 32'h0000_0002);
    tick();
    disp_valid_i = 1'b0;
    check("t2_wait0", iss_valid_o, 0);
    tick();
    check("t2_wait1", iss_valid_o, 0);
    cdb_valid_i = 1'b1;
    cdb_prd_i   = 12;
    #1;
    check("t2_no_comb_wake", iss_valid_o, 0);
    tick();
    idle_inputs();
    check("t2_woken", iss_valid_o, 1);
    check("t2_rob_tag", iss_rob_tag_o, 4);
    tick();
    check("t2_count0", count_o, 0);

    // Same-cycle CDB bypass at dispatch
    set_disp(5, 12, 7, 1, 20, 0, 32'h0000_0003);
    cdb_valid_i = 1'b1;
    cdb_prd_i   = 20;
    tick();
    idle_inputs();
    check("t3_bypass_valid", iss_valid_o, 1);
    check("t3_bypass_tag", iss_rob_tag_o, 5);
    tick();
    check("t3_count0", count_o, 0);

    // Broadcast of p0 wakes nothing
    iss_ready_i = 1'b0;
    set_disp(6, 13, 0, 0, 33, 0, 32'h0000_0004);
    cdb_valid_i = 1'b1;
    cdb_prd_i   = 0;
    tick();
    disp_valid_i = 1'b0;
    tick();
    cdb_valid_i = 1'b0;
    check("t4_p0_no_wake", iss_valid_o, 0);
    check("t4_count1", count_o, 1);
    cdb_valid_i = 1'b1;
    cdb_prd_i   = 33;
    tick();
    idle_inputs();
    check("t4_woken", iss_valid_o, 1);
    check("t4_rob_tag", iss_rob_tag_o, 6);
    check("t4_prs1_zero", iss_prs1_o, 0);
    iss_ready_i = 1'b1;
    tick();
    check("t4_count0", count_o, 0);

    // Fill all 8 entries unready; entries 2 and 5 share prs1=42
    iss_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_disp(7'(16 + i), 7'(50 + i), (i == 5) ? 7'd42 : 7'(40 + i), 0, 0, 0, 32'(i));
      tick();
    end
    disp_valid_i = 1'b0;
    check("t5_full_count", count_o, 8);
    check("t5_full_ready", disp_ready_o, 0);
    check("t5_none_ready", iss_valid_o, 0);
    cdb_valid_i = 1'b1;
    cdb_prd_i   = 42;
    tick();
    idle_inputs();
    check("t5_lowest_first", iss_rob_tag_o, 18);

    // Full queue: issue and dispatch together -> dispatch rejected
    iss_ready_i = 1'b1;
    set_disp(99, 60, 1, 1, 2, 1, 32'hDEAD_BEEF);
    #1;
    check("t6_full_reject", disp_ready_o, 0);
    tick();
    iss_ready_i = 1'b0;
    check("t6_count_after_issue", count_o, 7);
    check("t6_next_issue", iss_rob_tag_o, 21);
    check("t6_ready_again", disp_ready_o, 1);
    tick();
    disp_valid_i = 1'b0;
    check("t6_accepted_count", count_o, 8);
    check("t6_reuse_slot2", iss_rob_tag_o, 99);
    iss_ready_i = 1'b1;
    tick();
    check("t6_then_entry5", iss_rob_tag_o, 21);
    check("t6_count7", count_o, 7);
    tick();
    iss_ready_i = 1'b0;
    check("t6_count6", count_o, 6);
    check("t6_rest_unready", iss_valid_o, 0);

    // Flush overrides dispatch and wakeup
    flush_i = 1'b1;
    set_disp(100, 61, 1, 1, 2, 1, 32'h1);
    cdb_valid_i = 1'b1;
    cdb_prd_i   = 41;
    tick();
    idle_inputs();
    check("t7_flush_count", count_o, 0);
    check("t7_flush_iss", iss_valid_o, 0);
    check("t7_flush_ready", disp_ready_o, 1);
    tick();
    check("t7_flush_no_ghost", iss_valid_o, 0);

    // Refill 4, then the same via rst
    for (int i = 0; i < 4; i++) begin
      set_disp(7'(30 + i), 7'(70 + i), 7'(80 + i), 0, 0, 0, 32'(i));
      tick();
    end
    disp_valid_i = 1'b0;
    check("t8_held4", count_o, 4);
    rst = 1'b1;
    set_disp(101, 62, 1, 1, 2, 1, 32'h2);
    cdb_valid_i = 1'b1;
    cdb_prd_i   = 80;
    tick();
    rst = 1'b0;
    idle_inputs();
    check("t8_rst_count", count_o, 0);
    check("t8_rst_iss", iss_valid_o, 0);
    tick();
    check("t8_rst_no_ghost", iss_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
